shift_arbiter: RTL

//   Shares one 32-bit shift datapath between NREQ requesters (e.g. ALU issue, load/store align).

---
 rtl/shift_arbiter_pkg.sv | 15 +
 rtl/shift_arbiter_rr.sv | 47 ++++
 rtl/shift_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: op encodings and default widths.
package shift_arbiter_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int SHAMT_W_DEF = 5;

  // Shift op encoding on req_op; the reserved code behaves as SLL.
  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } op_e;

endpackage

// File: rtl/shift_arbiter_rr.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer, and advances the pointer past the winner on every grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;

  // Search from the pointer, wrapping, for the first asserted valid.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    if (en) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        cand = ID_W'((32'(ptr) + off) % NREQ);
        if (!grant_any && valid[cand]) begin
          grant_any = 1'b1;
          grant_id  = cand;
        end
      end
    end
    grant[grant_id] = grant_any;
  end

  // Pointer moves to the index after the winner; no grant leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      if (32'(grant_id) == NREQ - 1) ptr <= '0;
      else                           ptr <= grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shared 32-bit shifter with round-robin request arbitration and a single
// result register. Right shifts reuse the left-shift core via bit reversal.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int NREQ    = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [XLEN*NREQ-1:0]    req_data,
  input  logic [SHAMT_W*NREQ-1:0] req_shamt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [XLEN-1:0]         rsp_data
);

  function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] x);
    for (int unsigned i = 0; i < XLEN; i++) rev[i] = x[XLEN-1-i];
  endfunction

  logic            slot_free;
  logic            arb_en;
  logic [ID_W-1:0] gid;
  logic            gnt_any;

  assign slot_free = !rsp_valid || rsp_ready;
  assign arb_en    = slot_free && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_id  (gid),
    .grant_any (gnt_any)
  );

  logic [XLEN-1:0]    op_a;
  logic [SHAMT_W-1:0] op_s;
  op_e                op_sel;
  logic [XLEN-1:0]    sll_res;
  logic [XLEN-1:0]    srl_res;
  logic [XLEN-1:0]    sra_res;
  logic [XLEN-1:0]    ones_sh;
  logic [XLEN-1:0]    result;

  // Operand mux by grant, then one left-shift core serving all three ops.
  always_comb begin
    op_a    = req_data[gid*XLEN +: XLEN];
    op_s    = req_shamt[gid*SHAMT_W +: SHAMT_W];
    op_sel  = op_e'(req_op[gid*2 +: 2]);
    sll_res = op_a << op_s;
    srl_res = rev(rev(op_a) << op_s);
    ones_sh = {XLEN{1'b1}} << op_s;
    sra_res = srl_res | (op_a[XLEN-1] ? ~rev(ones_sh) : '0);
    case (op_sel)
      OP_SRL:  result = srl_res;
      OP_SRA:  result = sra_res;
      default: result = sll_res;
    endcase
  end

  // Result register: load on transfer, clear valid on drain, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (gnt_any) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gid;
      rsp_data  <= result;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
